hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Parametrised hazard/stall controller for the pipelined KGP-RISC core; successor to the single-cycle load-use detector.
- Sits beside the ID stage; drives PC write enable, IF/ID write enable, ID/EX bubble insertion and pipeline flushes.
- Adds configurable data-memory load latency (multi-cycle stall FSM), zero-register exemption, taken-branch flush, dmem busy freeze and a stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, cycles a load result trails its consumer; legal 1..15; each load-use hazard costs exactly LOAD_LAT stall cycles.
- ZERO_EXEMPT, 1, if 1 a hazard on register 0 never stalls.
- STORE_FWD, 1, if 1 a store in ID whose only match is rt (store data) does not stall.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_ex_readdmem  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_AW  load destination in EX.
- rs  in  REG_AW  ID source 1.
- rt  in  REG_AW  ID source 2.
- writedmem  in  1  ID instruction is a store.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- dmem_busy  in  1  data memory not ready; whole front end freezes.
- stall  out  1  insert bubble into ID/EX.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID update enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to NOP.
- stall_count  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Hazard term hz = id_ex_readdmem & (match_rs | match_rt).
  - match_x = (id_ex_rt == x), masked to 0 when ZERO_EXEMPT and id_ex_rt == 0.
  - If STORE_FWD and writedmem, match_rt is ignored; rs still counts.
- FSM states: IDLE, LOAD_WAIT. Down-counter wcnt is 4 bits.
- IDLE:
  - hz=1: stall=1, pc_write=0, if_id_write=0 (combinational, same cycle).
  - If LOAD_LAT>1: next state LOAD_WAIT, wcnt <= LOAD_LAT-1. Otherwise remain in IDLE.
- LOAD_WAIT:
  - stall=1, pc_write=0, if_id_write=0; wcnt decrements each cycle.
  - When wcnt==1, return to IDLE on the next edge.
  - hz is not re-evaluated in this state.
- Branch flush:
  - ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, stall=0.
  - FSM forced to IDLE and wcnt cleared; flush overrides both the hazard and LOAD_WAIT.
- dmem_busy=1 (highest priority):
  - pc_write=0, if_id_write=0, stall=0, flushes=0.
  - FSM and wcnt hold; stall_count does not increment.
  - A taken branch arriving during busy is ignored; EX holds it until busy drops.
- Default (no event): stall=0, pc_write=1, if_id_write=1, flushes=0.
- stall_count increments by 1 on every edge where stall=1 and saturates at 2^CNT_W-1.
- Reset (rst_n=0 at an edge):
  - FSM to IDLE, wcnt=0, stall_count=0.
  - While rst_n=0, outputs are forced to stall=0, pc_write=1, if_id_write=1, flushes=0.
  - Reset mid-LOAD_WAIT aborts the wait immediately.
- Stall, pc_write and if_id_write are mutually consistent: pc_write==if_id_write always, and stall=1 implies pc_write=0.

Test Plan:
- LOAD_LAT=1, readdmem=1, id_ex_rt=5, rs=5, writedmem=0 -> stall,pc_write,if_id_write=1,0,0 for exactly 1 cycle; stall_count=1.
- LOAD_LAT=3, hazard on rt=7, non-store -> stall held 3 consecutive cycles then 0,1,1; stall_count=3; a new hazard presented during the wait adds no cycles.
- id_ex_rt=0, rs=0, ZERO_EXEMPT=1 -> no stall; STORE_FWD=1, writedmem=1, rt=id_ex_rt=4, rs=2 -> no stall; same with rs=4 -> stall.
- LOAD_LAT=3, ex_branch_taken=1 in second wait cycle -> both flushes=1, pc_write=1, stall=0 that cycle; FSM IDLE next cycle; stall_count=2.
- dmem_busy=1 for 2 cycles during LOAD_WAIT -> pc_write=0, stall=0, wcnt frozen; total stall cycles still 3 after busy drops.
- rst_n=0 during LOAD_WAIT -> next cycle stall=0, pc_write=1, stall_count=0; CNT_W=2 with 5 stall cycles -> stall_count saturates at 3.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller for the KGP-RISC pipeline: load-use stalls with a
// configurable load latency, branch flushes, dmem busy freeze and a stall counter.
module hazard_stall_unit #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int STORE_FWD   = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_readdmem,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              writedmem,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // The hazard cycle itself is the first stall, so the wait covers the rest.
  localparam logic [3:0]       WAIT_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t             state_r, state_nxt_s;
  logic [3:0]         wcnt_r, wcnt_nxt_s;
  logic [CNT_W-1:0]   stall_count_r;
  logic               exempt_s, match_rs_s, match_rt_s, hz_s;
  logic               stall_s, pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s;

  assign exempt_s   = (ZERO_EXEMPT != 0) && (id_ex_rt == {REG_AW{1'b0}});
  assign match_rs_s = (id_ex_rt == rs) && !exempt_s;
  // Store data can be forwarded late, so an rt-only match on a store is harmless.
  assign match_rt_s = (id_ex_rt == rt) && !exempt_s && !((STORE_FWD != 0) && writedmem);
  assign hz_s       = id_ex_readdmem && (match_rs_s || match_rt_s);

  // Next-state and pipeline control; priority is reset, busy, branch, then stall.
  always_comb begin
    state_nxt_s   = state_r;
    wcnt_nxt_s    = wcnt_r;
    stall_s       = 1'b0;
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    if (!rst_n) begin
      state_nxt_s = IDLE;
      wcnt_nxt_s  = 4'd0;
    end else if (dmem_busy) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      state_nxt_s   = IDLE;
      wcnt_nxt_s    = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hz_s) begin
            stall_s       = 1'b1;
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            if (LOAD_LAT > 1) begin
              state_nxt_s = LOAD_WAIT;
              wcnt_nxt_s  = WAIT_INIT;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOAD_WAIT: begin
          stall_s       = 1'b1;
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          if (wcnt_r == 4'd1) begin
            state_nxt_s = IDLE;
            wcnt_nxt_s  = 4'd0;
          end else begin
            wcnt_nxt_s  = wcnt_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          wcnt_nxt_s  = 4'd0;
        end
      endcase
    end
  end

  // State, wait counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      wcnt_r        <= 4'd0;
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wcnt_r  <= wcnt_nxt_s;
      if (stall_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_W'(1'b1);
      end
    end
  end

  assign stall       = stall_s;
  assign pc_write    = pc_write_s;
  assign if_id_write = if_id_write_s;
  assign if_id_flush = if_id_flush_s;
  assign id_ex_flush = id_ex_flush_s;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: three parameterisations share one
// input stream; a directed table plus random stimulus against a cycle-budget model.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_ex_readdmem, writedmem, ex_branch_taken, dmem_busy;
  logic [4:0] id_ex_rt, rs, rt;

  wire [4:0]  o_a, o_b, o_c;   // {stall, pc_write, if_id_write, if_id_flush, id_ex_flush}
  wire [15:0] cnt_a, cnt_b;
  wire [1:0]  cnt_c;

  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(1), .STORE_FWD(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .id_ex_readdmem(id_ex_readdmem), .id_ex_rt(id_ex_rt),
    .rs(rs), .rt(rt), .writedmem(writedmem), .ex_branch_taken(ex_branch_taken),
    .dmem_busy(dmem_busy), .stall(o_a[4]), .pc_write(o_a[3]), .if_id_write(o_a[2]),
    .if_id_flush(o_a[1]), .id_ex_flush(o_a[0]), .stall_count(cnt_a));

  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(3), .ZERO_EXEMPT(1), .STORE_FWD(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .id_ex_readdmem(id_ex_readdmem), .id_ex_rt(id_ex_rt),
    .rs(rs), .rt(rt), .writedmem(writedmem), .ex_branch_taken(ex_branch_taken),
    .dmem_busy(dmem_busy), .stall(o_b[4]), .pc_write(o_b[3]), .if_id_write(o_b[2]),
    .if_id_flush(o_b[1]), .id_ex_flush(o_b[0]), .stall_count(cnt_b));

  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(2), .ZERO_EXEMPT(0), .STORE_FWD(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .id_ex_readdmem(id_ex_readdmem), .id_ex_rt(id_ex_rt),
    .rs(rs), .rt(rt), .writedmem(writedmem), .ex_branch_taken(ex_branch_taken),
    .dmem_busy(dmem_busy), .stall(o_c[4]), .pc_write(o_c[3]), .if_id_write(o_c[2]),
    .if_id_flush(o_c[1]), .id_ex_flush(o_c[0]), .stall_count(cnt_c));

  // Reference model: remaining stall cycles owed by the current load, plus a saturating tally.
  int lat_m  [3] = '{1, 3, 2};
  int ze_m   [3] = '{1, 1, 0};
  int sf_m   [3] = '{1, 1, 0};
  int cmax_m [3] = '{65535, 65535, 3};
  int rem_m  [3] = '{0, 0, 0};
  int cnt_m  [3] = '{0, 0, 0};

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       r, rd;
    logic [4:0] er, s, t;
    logic       w, b, bz;
    logic [4:0] exp_o;
    int         exp_cnt;
  } vec_t;
  vec_t tbl [24];

  function automatic logic model_hz(input int k);
    logic ex0, m_rs, m_rt;
    ex0  = (ze_m[k] != 0) && (id_ex_rt == 5'd0);
    m_rs = (id_ex_rt == rs) && !ex0;
    m_rt = (id_ex_rt == rt) && !ex0 && !((sf_m[k] != 0) && writedmem);
    return id_ex_readdmem && (m_rs || m_rt);
  endfunction

  function automatic logic [4:0] model_exp(input int k);
    if (!rst_n)                            return 5'b01100;
    else if (dmem_busy)                    return 5'b00000;
    else if (ex_branch_taken)              return 5'b01111;
    else if (rem_m[k] > 0 || model_hz(k))  return 5'b10000;
    else                                   return 5'b01100;
  endfunction

  task automatic model_step(input int k);
    logic hz;
    hz = model_hz(k);
    if (!rst_n) begin
      rem_m[k] = 0;
      cnt_m[k] = 0;
    end else if (dmem_busy) begin
      rem_m[k] = rem_m[k];
    end else if (ex_branch_taken) begin
      rem_m[k] = 0;
    end else if (rem_m[k] > 0 || hz) begin
      rem_m[k] = (rem_m[k] > 0) ? rem_m[k] - 1 : lat_m[k] - 1;
      if (cnt_m[k] < cmax_m[k]) cnt_m[k] = cnt_m[k] + 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs after the falling edge, compare, then advance the model.
  task automatic apply(input logic r, input logic rd, input logic [4:0] er, input logic [4:0] s,
                       input logic [4:0] t, input logic w, input logic b, input logic bz);
    @(negedge clk);
    rst_n = r; id_ex_readdmem = rd; id_ex_rt = er; rs = s; rt = t;
    writedmem = w; ex_branch_taken = b; dmem_busy = bz;
    #2;
    check("a_out", int'(o_a), int'(model_exp(0)));
    check("a_cnt", int'(cnt_a), cnt_m[0]);
    check("b_out", int'(o_b), int'(model_exp(1)));
    check("b_cnt", int'(cnt_b), cnt_m[1]);
    check("c_out", int'(o_c), int'(model_exp(2)));
    check("c_cnt", int'(cnt_c), cnt_m[2]);
    for (int k = 0; k < 3; k++) model_step(k);
  endtask

  initial begin
    //            r     rd    er     s      t      w     b     bz    exp_o     cnt
    tbl[0]  = '{1'b0, 1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 0};
    tbl[1]  = '{1'b1, 1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 1'b0, 1'b0, 5'b10000, 0};
    tbl[2]  = '{1'b1, 1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 1};
    tbl[3]  = '{1'b1, 1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 2};
    tbl[4]  = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 3};
    tbl[5]  = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 3};
    tbl[6]  = '{1'b1, 1'b1, 5'd4,  5'd2,  5'd4,  1'b1, 1'b0, 1'b0, 5'b01100, 3};
    tbl[7]  = '{1'b1, 1'b1, 5'd4,  5'd4,  5'd4,  1'b1, 1'b0, 1'b0, 5'b10000, 3};
    tbl[8]  = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 4};
    tbl[9]  = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'b01111, 5};
    tbl[10] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 5};
    tbl[11] = '{1'b1, 1'b1, 5'd3,  5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 5};
    tbl[12] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'b00000, 6};
    tbl[13] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'b00000, 6};
    tbl[14] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 6};
    tbl[15] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 7};
    tbl[16] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 8};
    tbl[17] = '{1'b1, 1'b1, 5'd6,  5'd6,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 8};
    tbl[18] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 9};
    tbl[19] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 0};
    tbl[20] = '{1'b1, 1'b1, 5'd12, 5'd0,  5'd12, 1'b0, 1'b0, 1'b0, 5'b10000, 0};
    tbl[21] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 1};
    tbl[22] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b10000, 2};
    tbl[23] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b01100, 3};

    rst_n = 1'b0; id_ex_readdmem = 1'b0; id_ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    writedmem = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);

    // Directed table against the LOAD_LAT=3 instance.
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].r, tbl[i].rd, tbl[i].er, tbl[i].s, tbl[i].t, tbl[i].w, tbl[i].b, tbl[i].bz);
      check($sformatf("tbl%0d_out", i), int'(o_b), int'(tbl[i].exp_o));
      check($sformatf("tbl%0d_cnt", i), int'(cnt_b), tbl[i].exp_cnt);
    end

    // Random traffic with small register sets so matches are frequent.
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0));
    end

    // Saturation of the 2-bit counter: five stall cycles after reset.
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) apply(1'b1, 1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("c_saturate", int'(cnt_c), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
